// File: rtl/rect_pkg.sv
// Shared constants and the default-width rectangle configuration record
// used by the multi-rectangle render stage.
package rect_pkg;

    localparam int REG_XCOORD       = 0;
    localparam int REG_YCOORD       = 1;
    localparam int REG_WIDTH        = 2;
    localparam int REG_HEIGHT       = 3;
    localparam int REG_COLOR        = 4;
    localparam int REG_ENABLE       = 5;
    localparam int REG_COMMIT_NOW   = 6;
    localparam int REG_COMMIT_FRAME = 7;

    // Alpha occupies color[COLOR_W-ALPHA_MSB : COLOR_W-ALPHA_LSB].
    localparam int ALPHA_MSB = 1;
    localparam int ALPHA_LSB = 8;

    localparam int DEF_X_W     = 11;
    localparam int DEF_Y_W     = 12;
    localparam int DEF_COLOR_W = 32;

    typedef struct packed {
        logic [DEF_X_W:0]       xcoord;
        logic [DEF_Y_W:0]       ycoord;
        logic [DEF_X_W:0]       width;
        logic [DEF_Y_W:0]       height;
        logic [DEF_COLOR_W-1:0] color;
        logic                   enable;
    } rect_cfg_t;

endpackage

// File: rtl/rect_hit_test.sv
// Combinational containment test of one pixel against one rectangle,
// including the enable bit and alpha-zero transparency.
module rect_hit_test
    import rect_pkg::*;
#(
    parameter int  X_W     = 11,
    parameter int  Y_W     = 12,
    parameter int  COLOR_W = 32,
    parameter type cfg_t   = rect_cfg_t
) (
    input  logic [X_W-1:0] i_x,
    input  logic [Y_W-1:0] i_y,
    input  cfg_t           i_cfg,
    output logic           o_hit
);

    logic [X_W+1:0] w_x_pix;
    logic [X_W+1:0] w_x_lo;
    logic [X_W+1:0] w_x_end;
    logic [Y_W+1:0] w_y_pix;
    logic [Y_W+1:0] w_y_lo;
    logic [Y_W+1:0] w_y_end;
    logic [ALPHA_LSB-ALPHA_MSB:0] w_alpha;

    // One extra bit on the end sums so a rectangle near the edge never wraps.
    assign w_x_pix = {2'b00, i_x};
    assign w_x_lo  = {1'b0, i_cfg.xcoord};
    assign w_x_end = {1'b0, i_cfg.xcoord} + {1'b0, i_cfg.width};
    assign w_y_pix = {2'b00, i_y};
    assign w_y_lo  = {1'b0, i_cfg.ycoord};
    assign w_y_end = {1'b0, i_cfg.ycoord} + {1'b0, i_cfg.height};
    assign w_alpha = i_cfg.color[COLOR_W-ALPHA_MSB:COLOR_W-ALPHA_LSB];

    assign o_hit = i_cfg.enable
                && (w_x_pix >= w_x_lo) && (w_x_pix < w_x_end)
                && (w_y_pix >= w_y_lo) && (w_y_pix < w_y_end)
                && (w_alpha != '0);

endmodule

// File: rtl/multi_rect_renderer.sv
// Daisy-chained render stage owning NUM_RECTS rectangles with shadow/active
// register banks and a fixed two-stage pixel pipeline (lowest index wins).
module multi_rect_renderer
    import rect_pkg::*;
#(
    parameter int SHAPE_ID_BASE = 0,
    parameter int NUM_RECTS     = 4,
    parameter int X_W           = 11,
    parameter int Y_W           = 12,
    parameter int COLOR_W       = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               program_in,
    input  logic [X_W-1:0]     x,
    input  logic [Y_W-1:0]     y,
    input  logic [COLOR_W-1:0] data_in,
    output logic               program_out,
    output logic [X_W-1:0]     x_out,
    output logic [Y_W-1:0]     y_out,
    output logic [COLOR_W-1:0] data_out
);

    typedef struct packed {
        logic [X_W:0]         xcoord;
        logic [Y_W:0]         ycoord;
        logic [X_W:0]         width;
        logic [Y_W:0]         height;
        logic [COLOR_W-1:0]   color;
        logic                 enable;
    } cfg_t;

    localparam cfg_t CFG_RESET = '{xcoord: '0, ycoord: '0, width: '0,
                                   height: '0, color: '1, enable: 1'b0};

    cfg_t r_shadow [NUM_RECTS];
    cfg_t r_active [NUM_RECTS];
    cfg_t w_eval_cfg [NUM_RECTS];
    logic r_commit_pending;

    logic [NUM_RECTS-1:0] w_sel;
    logic [NUM_RECTS-1:0] w_hit;
    logic [31:0]          w_x_ext;
    logic                 w_owned;
    logic                 w_commit_now;
    logic                 w_arm;
    logic                 w_frame_commit;

    logic                 r_s1_prog;
    logic [X_W-1:0]       r_s1_x;
    logic [Y_W-1:0]       r_s1_y;
    logic [COLOR_W-1:0]   r_s1_data;
    logic [NUM_RECTS-1:0] r_s1_hit;
    logic [COLOR_W-1:0]   r_s1_color [NUM_RECTS];
    logic [COLOR_W-1:0]   w_pix;

    assign w_x_ext = 32'(x);

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_RECTS; i++) begin
            w_sel[i] = program_in && (w_x_ext == 32'(SHAPE_ID_BASE + i));
        end
    end

    assign w_owned        = |w_sel;
    assign w_commit_now   = w_owned && (y == Y_W'(REG_COMMIT_NOW));
    assign w_arm          = w_owned && (y == Y_W'(REG_COMMIT_FRAME));
    assign w_frame_commit = !program_in && (x == '0) && (y == '0) && r_commit_pending;

    // The frame-start pixel already sees the configuration it commits.
    always_comb begin
        for (int i = 0; i < NUM_RECTS; i++) begin
            w_eval_cfg[i] = w_frame_commit ? r_shadow[i] : r_active[i];
        end
    end

    for (genvar gi = 0; gi < NUM_RECTS; gi++) begin : g_hit
        rect_hit_test #(
            .X_W     (X_W),
            .Y_W     (Y_W),
            .COLOR_W (COLOR_W),
            .cfg_t   (cfg_t)
        ) u_hit (
            .i_x   (x),
            .i_y   (y),
            .i_cfg (w_eval_cfg[gi]),
            .o_hit (w_hit[gi])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_RECTS; i++) begin
                r_shadow[i] <= CFG_RESET;
                r_active[i] <= CFG_RESET;
            end
            r_commit_pending <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_RECTS; i++) begin
                if (w_sel[i]) begin
                    case (y)
                        Y_W'(REG_XCOORD): r_shadow[i].xcoord <= data_in[X_W:0];
                        Y_W'(REG_YCOORD): r_shadow[i].ycoord <= data_in[Y_W:0];
                        Y_W'(REG_WIDTH):  r_shadow[i].width  <= data_in[X_W:0];
                        Y_W'(REG_HEIGHT): r_shadow[i].height <= data_in[Y_W:0];
                        Y_W'(REG_COLOR):  r_shadow[i].color  <= data_in;
                        Y_W'(REG_ENABLE): r_shadow[i].enable <= data_in[0];
                        default: ;
                    endcase
                end
                if (w_commit_now || w_frame_commit) begin
                    r_active[i] <= r_shadow[i];
                end
            end
            if (w_frame_commit) begin
                r_commit_pending <= 1'b0;
            end else if (w_arm) begin
                r_commit_pending <= 1'b1;
            end
        end
    end

    always_comb begin
        w_pix = r_s1_data;
        for (int i = NUM_RECTS - 1; i >= 0; i--) begin
            if (r_s1_hit[i]) begin
                w_pix = r_s1_color[i];
            end
        end
    end

    // Free-running pipeline: one beat per cycle, no stall or backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_prog   <= 1'b0;
            r_s1_x      <= '0;
            r_s1_y      <= '0;
            r_s1_data   <= '0;
            r_s1_hit    <= '0;
            for (int i = 0; i < NUM_RECTS; i++) begin
                r_s1_color[i] <= '0;
            end
            program_out <= 1'b0;
            x_out       <= '0;
            y_out       <= '0;
            data_out    <= '0;
        end else begin
            r_s1_prog   <= program_in;
            r_s1_x      <= x;
            r_s1_y      <= y;
            r_s1_data   <= data_in;
            r_s1_hit    <= program_in ? '0 : w_hit;
            for (int i = 0; i < NUM_RECTS; i++) begin
                r_s1_color[i] <= w_eval_cfg[i].color;
            end
            program_out <= r_s1_prog;
            x_out       <= r_s1_x;
            y_out       <= r_s1_y;
            data_out    <= w_pix;
        end
    end

endmodule

// File: tb/tb_multi_rect_renderer.sv
// Directed vector bench for multi_rect_renderer: every beat's expected output
// is queued and compared two cycles after it is issued.
module tb_multi_rect_renderer;

    localparam int W = 1 + 11 + 12 + 32;

    logic        clk;
    logic        rst_n;
    logic        program_in;
    logic [10:0] x;
    logic [11:0] y;
    logic [31:0] data_in;
    logic        program_out;
    logic [10:0] x_out;
    logic [11:0] y_out;
    logic [31:0] data_out;

    int checks = 0;
    int errors = 0;
    int beat_no = 0;

    logic [W-1:0] exp_q[$];

    typedef struct {
        logic        prog;
        logic [10:0] vx;
        logic [11:0] vy;
        logic [31:0] d;
        logic [31:0] e;
    } vec_t;

    vec_t tbl[$];

    multi_rect_renderer #(
        .SHAPE_ID_BASE (0),
        .NUM_RECTS     (4),
        .X_W           (11),
        .Y_W           (12),
        .COLOR_W       (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .program_in  (program_in),
        .x           (x),
        .y           (y),
        .data_in     (data_in),
        .program_out (program_out),
        .x_out       (x_out),
        .y_out       (y_out),
        .data_out    (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic beat(input logic p, input logic [10:0] bx, input logic [11:0] by,
                        input logic [31:0] bd, input logic [31:0] be);
        logic [W-1:0] exp;
        program_in = p;
        x          = bx;
        y          = by;
        data_in    = bd;
        @(posedge clk);
        #1;
        beat_no++;
        exp_q.push_back({p, bx, by, be});
        if (exp_q.size() == 2) begin
            exp = exp_q.pop_front();
            check($sformatf("beat %0d", beat_no - 1),
                  {program_out, x_out, y_out, data_out}, exp);
        end
    endtask

    task automatic flush();
        logic [W-1:0] exp;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check("flush", {program_out, x_out, y_out, data_out}, exp);
        end
    endtask

    task automatic add_prog(input int s, input int r, input logic [31:0] v);
        tbl.push_back('{1'b1, 11'(s), 12'(r), v, v});
    endtask

    task automatic add_pix(input int px, input int py, input logic [31:0] d, input logic [31:0] e);
        tbl.push_back('{1'b0, 11'(px), 12'(py), d, e});
    endtask

    initial begin
        rst_n      = 1'b0;
        program_in = 1'b0;
        x          = '0;
        y          = '0;
        data_in    = '0;

        // Plain pass-through after reset
        add_pix(5, 5, 32'h11223344, 32'h11223344);
        // Rect0 shadow program; invisible until committed
        add_prog(0, 0, 10);
        add_prog(0, 1, 10);
        add_prog(0, 2, 4);
        add_prog(0, 3, 2);
        add_prog(0, 4, 32'hFF00FF00);
        add_prog(0, 5, 1);
        add_pix(13, 11, 32'hAAAA0001, 32'hAAAA0001);
        add_prog(0, 6, 0);
        add_pix(13, 11, 32'h00000001, 32'hFF00FF00);
        add_pix(10, 10, 32'h00000005, 32'hFF00FF00);
        add_pix(14, 11, 32'h00000002, 32'h00000002);
        add_pix(10, 12, 32'h00000003, 32'h00000003);
        add_pix(9, 10, 32'h00000004, 32'h00000004);
        add_pix(13, 9, 32'h00000006, 32'h00000006);
        // Overlap priority: rect0 over rect1
        add_prog(0, 0, 20);
        add_prog(0, 1, 20);
        add_prog(0, 2, 1);
        add_prog(0, 3, 1);
        add_prog(0, 4, 32'hFFAA0000);
        add_prog(1, 0, 18);
        add_prog(1, 1, 19);
        add_prog(1, 2, 5);
        add_prog(1, 3, 5);
        add_prog(1, 4, 32'hFFBB0000);
        add_prog(1, 5, 1);
        add_prog(1, 6, 0);
        add_pix(20, 20, 32'h00000010, 32'hFFAA0000);
        add_pix(21, 21, 32'h00000011, 32'hFFBB0000);
        add_prog(0, 5, 0);
        add_prog(0, 6, 0);
        add_pix(20, 20, 32'h00000012, 32'hFFBB0000);
        // Frame commit on rect2
        add_prog(2, 0, 0);
        add_prog(2, 1, 0);
        add_prog(2, 2, 40);
        add_prog(2, 3, 40);
        add_prog(2, 4, 32'hFF222222);
        add_prog(2, 5, 1);
        add_prog(2, 6, 0);
        add_pix(30, 30, 32'h00000020, 32'hFF222222);
        add_prog(2, 4, 32'hFF0000FF);
        add_prog(2, 7, 0);
        add_prog(2, 7, 0);
        add_pix(30, 30, 32'h00000021, 32'hFF222222);
        add_pix(0, 0, 32'h00000022, 32'hFF0000FF);
        add_pix(30, 30, 32'h00000023, 32'hFF0000FF);
        add_prog(2, 4, 32'hFF333333);
        add_pix(0, 0, 32'h00000024, 32'hFF0000FF);
        // Alpha zero is transparent
        add_prog(2, 4, 32'h00123456);
        add_prog(2, 6, 0);
        add_pix(5, 5, 32'h00000077, 32'h00000077);
        // Right-edge rectangle does not wrap to x=0
        add_prog(3, 0, 2047);
        add_prog(3, 1, 0);
        add_prog(3, 2, 2047);
        add_prog(3, 3, 100);
        add_prog(3, 4, 32'hFF444444);
        add_prog(3, 5, 1);
        add_prog(3, 6, 0);
        add_pix(0, 5, 32'h00000030, 32'h00000030);
        add_pix(2047, 5, 32'h00000031, 32'hFF444444);
        add_pix(2046, 5, 32'h00000032, 32'h00000032);
        // Foreign shape id and unknown reg id are ignored
        add_prog(4, 5, 0);
        add_prog(4, 6, 0);
        add_prog(3, 8, 0);
        add_prog(3, 6, 0);
        add_pix(2047, 5, 32'h00000033, 32'hFF444444);

        repeat (2) @(posedge clk);
        #1;
        check("reset outputs", {program_out, x_out, y_out, data_out}, '0);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            beat(tbl[i].prog, tbl[i].vx, tbl[i].vy, tbl[i].d, tbl[i].e);
        end
        flush();

        // Arm a frame commit, then reset mid-stream
        beat(1'b1, 11'd1, 12'd7, 32'h0, 32'h0);
        beat(1'b0, 11'd21, 12'd21, 32'h00000040, 32'hFFBB0000);
        beat(1'b0, 11'd21, 12'd21, 32'h00000041, 32'hFFBB0000);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset", {program_out, x_out, y_out, data_out}, '0);
        exp_q.delete();
        @(posedge clk);
        #1;
        check("held reset", {program_out, x_out, y_out, data_out}, '0);
        rst_n = 1'b1;

        // Configuration and pending commit are gone after reset
        beat(1'b0, 11'd21, 12'd21, 32'h00000050, 32'h00000050);
        beat(1'b0, 11'd0, 12'd0, 32'h00000051, 32'h00000051);
        beat(1'b0, 11'd20, 12'd20, 32'h00000052, 32'h00000052);
        flush();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
